input_mems_pp: RTL

Double-buffered successor to the single-set input memory of the 2D convolution accelerator. It accepts W, B and X over one AXI-Stream slave and stores X in two ping-pong banks. The next X can stream in while the compute engine is still reading the previous one. It sits between the AXIS input and the MAC datapath, and exports K, B and synchronous-read ports for W and X.

---
 rtl/input_mems_pp.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/input_mems_pp.sv
// ---------------------------------------------------------------------------
// input_mems_pp
//
// Double-buffered input memory for the 2D convolution accelerator. One
// AXI-Stream slave carries a W/B/X set (new_W=1) or an X-only set (new_W=0).
// X is stored in two ping-pong banks, so the next image can stream in while
// the compute engine is still reading the previous one.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   AXIS_TDATA       input word
//   AXIS_TVALID      source valid
//   AXIS_TUSER       [0] = new_W, [K_BITS:1] = K (sampled on the first word)
//   AXIS_TREADY      sink ready
//   inputs_loaded    read bank holds a complete X; W/K/B are valid
//   compute_finished one-cycle pulse that releases the read bank
//   K, B             current kernel size and signed bias
//   X_read_addr      row-major X address into the read bank
//   X_data           X word, one cycle after the address
//   W_read_addr      packed row-major W address i*K+j
//   W_data           W word, one cycle after the address
//   x_banks_full     full flag per X bank
// ---------------------------------------------------------------------------
module input_mems_pp #(
  parameter int INW  = 24,
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int X_ADDR_BITS = $clog2(R * C),
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INW-1:0]                AXIS_TDATA,
  input  logic                          AXIS_TVALID,
  input  logic [K_BITS:0]               AXIS_TUSER,
  output logic                          AXIS_TREADY,
  output logic                          inputs_loaded,
  input  logic                          compute_finished,
  output logic [K_BITS-1:0]             K,
  output logic signed [INW-1:0]         B,
  input  logic [X_ADDR_BITS-1:0]        X_read_addr,
  output logic signed [INW-1:0]         X_data,
  input  logic [W_ADDR_BITS-1:0]        W_read_addr,
  output logic signed [INW-1:0]         W_data,
  output logic [1:0]                    x_banks_full
);

  localparam int XDEPTH = R * C;
  localparam int WDEPTH = MAXK * MAXK;
  localparam logic [X_ADDR_BITS-1:0] X_LAST = X_ADDR_BITS'(XDEPTH - 1);
  localparam logic [K_BITS-1:0]      K_MIN  = K_BITS'(2);
  localparam logic [K_BITS-1:0]      K_MAX  = K_BITS'(MAXK);

  typedef enum logic [1:0] {
    L_IDLE,
    L_W,
    L_B,
    L_X
  } load_state_e;

  load_state_e             state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic [K_BITS-1:0]       k_q, k_d;
  logic [INW-1:0]          b_q, b_d;
  logic [W_ADDR_BITS-1:0]  w_cnt_q, w_cnt_d;
  logic [X_ADDR_BITS-1:0]  x_cnt_q, x_cnt_d;

  logic [INW-1:0] xmem0 [XDEPTH];
  logic [INW-1:0] xmem1 [XDEPTH];
  logic [INW-1:0] wmem  [WDEPTH];
  logic [INW-1:0] x_rd_q;
  logic [INW-1:0] w_rd_q;

  logic                    new_w;
  logic [K_BITS-1:0]       k_in;
  logic [K_BITS-1:0]       k_clamped;
  logic                    ready_int;
  logic                    xfer;
  logic                    release_rd;
  logic [2*K_BITS-1:0]     k_ext;
  logic [2*K_BITS-1:0]     k_sq;
  logic                    w_is_last;
  logic                    x_we;
  logic                    w_we;
  logic [X_ADDR_BITS-1:0]  x_waddr;
  logic [W_ADDR_BITS-1:0]  w_waddr;

  assign new_w = AXIS_TUSER[0];
  assign k_in  = AXIS_TUSER[K_BITS:1];

  always_comb begin
    k_clamped = k_in;
    if (k_in < K_MIN) begin
      k_clamped = K_MIN;
    end else if (k_in > K_MAX) begin
      k_clamped = K_MAX;
    end
  end

  // A new W set may only start with both banks empty, so K, B and W never
  // change underneath a compute. An X-only set just needs its target bank free.
  always_comb begin
    ready_int = 1'b1;
    if (state_q == L_IDLE) begin
      if (new_w) begin
        ready_int = (full_q == 2'b00);
      end else begin
        ready_int = !full_q[wr_bank_q];
      end
    end
  end

  assign AXIS_TREADY = reset & ready_int;
  assign xfer        = AXIS_TVALID & AXIS_TREADY;

  // Release is only honoured when the read bank actually holds data.
  assign release_rd = compute_finished & full_q[rd_bank_q];

  assign k_ext     = (2*K_BITS)'(k_q);
  assign k_sq      = k_ext * k_ext;
  assign w_is_last = ((2*K_BITS)'(w_cnt_q) == (k_sq - 1'b1));

  assign x_we    = xfer & (((state_q == L_IDLE) & !new_w) | (state_q == L_X));
  assign w_we    = xfer & (((state_q == L_IDLE) & new_w) | (state_q == L_W));
  assign x_waddr = (state_q == L_IDLE) ? '0 : x_cnt_q;
  assign w_waddr = (state_q == L_IDLE) ? '0 : w_cnt_q;

  // Load sequencing and bank bookkeeping. A final X write into one bank and a
  // release of the other bank can land on the same edge; both are applied.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    k_d       = k_q;
    b_d       = b_q;
    w_cnt_d   = w_cnt_q;
    x_cnt_d   = x_cnt_q;

    if (release_rd) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    case (state_q)
      L_IDLE: begin
        if (xfer) begin
          if (new_w) begin
            k_d     = k_clamped;
            w_cnt_d = W_ADDR_BITS'(1);
            state_d = L_W;
          end else begin
            x_cnt_d = X_ADDR_BITS'(1);
            state_d = L_X;
          end
        end
      end
      L_W: begin
        if (xfer) begin
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_is_last) begin
            state_d = L_B;
          end
        end
      end
      L_B: begin
        if (xfer) begin
          b_d     = AXIS_TDATA;
          x_cnt_d = '0;
          state_d = L_X;
        end
      end
      L_X: begin
        if (xfer) begin
          x_cnt_d = x_cnt_q + 1'b1;
          if (x_cnt_q == X_LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            x_cnt_d           = '0;
            state_d           = L_IDLE;
          end
        end
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= L_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      k_q       <= '0;
      b_q       <= '0;
      w_cnt_q   <= '0;
      x_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      k_q       <= k_d;
      b_q       <= b_d;
      w_cnt_q   <= w_cnt_d;
      x_cnt_q   <= x_cnt_d;
    end
  end

  // Storage is not reset. Reads are synchronous and read-before-write, and the
  // X read uses the bank pointer as it stood when the address was presented.
  always_ff @(posedge clk) begin
    if (x_we) begin
      if (wr_bank_q) begin
        xmem1[x_waddr] <= AXIS_TDATA;
      end else begin
        xmem0[x_waddr] <= AXIS_TDATA;
      end
    end
    if (w_we) begin
      wmem[w_waddr] <= AXIS_TDATA;
    end
    x_rd_q <= rd_bank_q ? xmem1[X_read_addr] : xmem0[X_read_addr];
    w_rd_q <= wmem[W_read_addr];
  end

  assign X_data        = x_rd_q;
  assign W_data        = w_rd_q;
  assign K             = k_q;
  assign B             = b_q;
  assign inputs_loaded = full_q[rd_bank_q];
  assign x_banks_full  = full_q;

endmodule
